// File: rtl/msg_buffer_pkg.sv
// Shared types and sizing for the message staging buffer.
// The read FSM state type and bank geometry live here.
package msg_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } rd_state_t;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int BLOCK_WORDS    = 1 << ADDR_W_DEFAULT;
    localparam int NUM_BANKS      = 2;

endpackage

// File: rtl/msg_bank.sv
// One block of message storage: synchronous write port, asynchronous read
// port so the hasher sees its word in the same cycle it presents the address.
module msg_bank
    import msg_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/msg_buffer.sv
// Ping-pong message block buffer: the writer fills one bank while the hasher
// reads the other; a bank is handed back when the hasher reports completion.
module msg_buffer
    import msg_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wordIn,
    input  logic              wordValid,
    output logic              wordReady,
    output logic              start,
    input  logic [ADDR_W-1:0] messageAddress,
    input  logic              messageRead,
    output logic [DATA_W-1:0] messageIn,
    input  logic              dataOutValid,
    output logic              busy,
    output logic [7:0]        blocksDone
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_count;
    logic [1:0]        r_bank_full;
    logic [7:0]        r_blocks_done;
    rd_state_t         r_state;

    rd_state_t         w_state_next;
    logic [1:0]        w_bank_full_next;
    logic              w_accept;
    logic              w_fill;
    logic              w_release;
    logic              w_start;
    logic [DATA_W-1:0] w_rdata [NUM_BANKS];
    logic              w_unused;

    // messageRead carries no state effect; it is accepted for interface symmetry.
    assign w_unused  = messageRead;

    assign wordReady = !r_bank_full[r_wr_bank];
    assign w_accept  = wordValid && wordReady;
    assign w_fill    = w_accept && (r_wr_count == LAST_ADDR);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic w_we;
            assign w_we = w_accept && (int'(r_wr_bank) == gi);

            msg_bank #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_bank (
                .clk  (clk),
                .we   (w_we),
                .waddr(r_wr_count),
                .wdata(wordIn),
                .raddr(messageAddress),
                .rdata(w_rdata[gi])
            );
        end
    endgenerate

    assign messageIn = w_rdata[r_rd_bank];

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_start      = 1'b1;
                w_state_next = BUSY;
            end
            BUSY: begin
                if (dataOutValid) begin
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Fill and release always target different banks, so both may apply at once.
    always_comb begin
        w_bank_full_next = r_bank_full;
        if (w_release) begin
            w_bank_full_next[r_rd_bank] = 1'b0;
        end
        if (w_fill) begin
            w_bank_full_next[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_count    <= '0;
            r_bank_full   <= 2'b00;
            r_blocks_done <= 8'd0;
            r_state       <= IDLE;
        end else begin
            r_state     <= w_state_next;
            r_bank_full <= w_bank_full_next;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            if (w_fill) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank     <= !r_rd_bank;
                r_blocks_done <= r_blocks_done + 8'd1;
            end
        end
    end

    assign start      = w_start;
    assign busy       = (r_state != IDLE);
    assign blocksDone = r_blocks_done;

endmodule

// File: tb/tb_msg_buffer.sv
// Self-checking bench for msg_buffer: scoreboard of accepted words checked
// against hasher-side reads, plus timing checks on start/release/backpressure.
`timescale 1ns/1ps
module tb_msg_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wordIn = '0;
    logic        wordValid = 1'b0;
    logic        wordReady;
    logic        start;
    logic [3:0]  messageAddress = '0;
    logic        messageRead = 1'b0;
    logic [31:0] messageIn;
    logic        dataOutValid = 1'b0;
    logic        busy;
    logic [7:0]  blocksDone;

    msg_buffer #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .wordIn        (wordIn),
        .wordValid     (wordValid),
        .wordReady     (wordReady),
        .start         (start),
        .messageAddress(messageAddress),
        .messageRead   (messageRead),
        .messageIn     (messageIn),
        .dataOutValid  (dataOutValid),
        .busy          (busy),
        .blocksDone    (blocksDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp_data;
    } sweep_vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          start_cyc = -1;
    logic [31:0] q[$];
    int          acc_cyc[64];
    int          ready_wait[64];

    // start is read before the edge updates it, so start_cyc matches the
    // cycle index seen by the bench's post-edge sample point.
    always @(posedge clk) begin
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        wordValid    = 1'b0;
        dataOutValid = 1'b0;
        messageRead  = 1'b0;
        #1;
        check("reset_wordReady", {31'd0, wordReady}, 32'd1);
        check("reset_start", {31'd0, start}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_blocksDone", {24'd0, blocksDone}, 32'd0);
        step();
        step();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        logic acc;
        int   w;
        for (int i = 0; i < n; i++) begin
            wordValid = 1'b1;
            wordIn    = base + 32'(i);
            w         = 0;
            acc       = 1'b0;
            while (!acc && w < 500) begin
                acc = wordReady;
                step();
                w++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: actual word %0d not accepted required accept", i);
                break;
            end
            q.push_back(base + 32'(i));
            acc_cyc[i]    = cyc;
            ready_wait[i] = w - 1;
        end
        wordValid = 1'b0;
    endtask

    task automatic wait_start(output int s_at);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: actual no start required start pulse");
        end
        s_at = cyc;
    endtask

    task automatic read_block();
        logic [31:0] exp;
        messageRead = 1'b1;
        for (int k = 0; k < 16; k++) begin
            messageAddress = k[3:0];
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: actual empty required word for addr %0d", k);
            end else begin
                exp = q.pop_front();
                check($sformatf("messageIn_addr%0d", k), messageIn, exp);
            end
            step();
        end
        messageRead = 1'b0;
    endtask

    task automatic release_bank(output int d_at);
        dataOutValid = 1'b1;
        step();
        dataOutValid = 1'b0;
        d_at = cyc;
        check("busy_after_release", {31'd0, busy}, 32'd0);
    endtask

    task automatic hasher(input int hold, output int s_at, output int d_at);
        wait_start(s_at);
        check("busy_in_start", {31'd0, busy}, 32'd1);
        read_block();
        for (int i = 16; i < hold; i++) step();
        release_bank(d_at);
        $display("block consumed: start@%0d release@%0d blocksDone=%0d", s_at, d_at, blocksDone);
    endtask

    initial begin
        sweep_vec_t sweep_tbl[16];
        int s1, d1, s2, d2, s3, d3, snap, stalls;
        logic [31:0] base;

        for (int k = 0; k < 16; k++) begin
            sweep_tbl[k].addr     = k[3:0];
            sweep_tbl[k].exp_data = 32'h1000_0000 + 32'(k);
        end

        // Test 1: reset, then reset mid-fill after 7 words
        do_reset();
        push_words(7, 32'hDEAD_0000);
        do_reset();
        snap = start_cnt;
        push_words(16, 32'h0100_0000);
        hasher(16, s1, d1);
        check("t1_start_after_16_new", 32'(s1), 32'(acc_cyc[15] + 1));
        check("t1_single_start", 32'(start_cnt - snap), 32'd1);

        // Test 2: single block, table-driven address sweep
        do_reset();
        push_words(16, 32'h1000_0000);
        check("t2_start_low_at_E", {31'd0, start}, 32'd0);
        step();
        check("t2_start_high_E1", {31'd0, start}, 32'd1);
        step();
        check("t2_start_low_E2", {31'd0, start}, 32'd0);
        check("t2_busy_E2", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            messageAddress = sweep_tbl[i].addr;
            #1;
            check($sformatf("t2_sweep%0d", i), messageIn, sweep_tbl[i].exp_data);
            step();
        end
        q.delete();
        release_bank(d1);
        check("t2_blocksDone", {24'd0, blocksDone}, 32'd1);

        // Test 3: ping-pong, 32 continuous words, hasher holds 40 cycles
        do_reset();
        fork
            push_words(32, 32'h2000_0000);
            begin
                hasher(40, s1, d1);
                hasher(40, s2, d2);
            end
        join
        stalls = 0;
        for (int i = 0; i < 32; i++) stalls += ready_wait[i];
        check("t3_no_stall", 32'(stalls), 32'd0);
        check("t3_first_start", 32'(s1), 32'(acc_cyc[15] + 1));
        check("t3_second_start_D1", 32'(s2), 32'(d1 + 1));
        check("t3_blocksDone", {24'd0, blocksDone}, 32'd2);

        // Test 4: backpressure, 48 words with stalled hasher
        do_reset();
        fork
            push_words(48, 32'h4000_0000);
            begin
                hasher(60, s1, d1);
                hasher(16, s2, d2);
                hasher(16, s3, d3);
            end
        join
        stalls = 0;
        for (int i = 0; i < 32; i++) stalls += ready_wait[i];
        check("t4_first32_no_stall", 32'(stalls), 32'd0);
        check("t4_word33_stalled", (ready_wait[32] > 0) ? 32'd1 : 32'd0, 32'd1);
        check("t4_word33_after_release", 32'(acc_cyc[32]), 32'(d1 + 1));
        check("t4_scoreboard_drained", 32'(q.size()), 32'd0);
        check("t4_blocksDone", {24'd0, blocksDone}, 32'd3);

        // Test 5: 16th word of bank 1 on the same edge that releases bank 0
        do_reset();
        base = 32'h5000_0000;
        push_words(16, base);
        wait_start(s1);
        read_block();
        push_words(15, base + 32'd16);
        wordValid    = 1'b1;
        wordIn       = base + 32'd31;
        dataOutValid = 1'b1;
        check("t5_ready_before", {31'd0, wordReady}, 32'd1);
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        step();
        wordValid    = 1'b0;
        dataOutValid = 1'b0;
        q.push_back(base + 32'd31);
        check("t5_released_idle", {31'd0, busy}, 32'd0);
        check("t5_blocksDone", {24'd0, blocksDone}, 32'd1);
        check("t5_bank0_free", {31'd0, wordReady}, 32'd1);
        step();
        check("t5_start_bank1", {31'd0, start}, 32'd1);
        read_block();
        release_bank(d1);
        check("t5_blocksDone_2", {24'd0, blocksDone}, 32'd2);

        // Test 6: 256 blocks wrap blocksDone, then a spurious release in IDLE
        do_reset();
        for (int b = 0; b < 256; b++) begin
            fork
                push_words(16, 32'(b) << 16);
                hasher(16, s1, d1);
            join
            if (b >= 253) begin
                check($sformatf("t6_blocksDone_%0d", b), {24'd0, blocksDone}, 32'((b + 1) % 256));
            end
        end
        check("t6_wrap_zero", {24'd0, blocksDone}, 32'd0);
        dataOutValid = 1'b1;
        step();
        dataOutValid = 1'b0;
        check("t6_spurious_blocksDone", {24'd0, blocksDone}, 32'd0);
        check("t6_spurious_busy", {31'd0, busy}, 32'd0);
        step();
        check("t6_spurious_start", {31'd0, start}, 32'd0);
        check("t6_spurious_ready", {31'd0, wordReady}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
